// File: rtl/n64_pkg.sv
// rtl/n64_pkg.sv - shared timing constants, receive states and response field positions
package n64_pkg;

  localparam int CLK_PER_BIT  = 400;
  localparam int START        = 100;
  localparam int DATA         = 300;
  localparam int STOP         = 400;
  localparam int SAMPLE_AT    = 200;
  localparam int RESP_TIMEOUT = 1000;
  localparam int BIT_TIMEOUT  = 800;
  localparam int NUM_BITS     = 32;

  localparam int BTN_MSB = 31;
  localparam int BTN_LSB = 16;
  localparam int JX_MSB  = 15;
  localparam int JX_LSB  = 8;
  localparam int JY_MSB  = 7;
  localparam int JY_LSB  = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_MEASURE,
    S_STOP
  } rx_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/n64_sync_edge.sv
// rtl/n64_sync_edge.sv - two-flop line synchronizer with registered falling-edge strobe
module n64_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_data,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_level;
  logic r_prev;
  logic r_fall;

  // Reset to 1 so an idle-high line never produces a spurious edge after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b1;
      r_level <= 1'b1;
      r_prev  <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_meta  <= i_data;
      r_level <= r_meta;
      r_prev  <= r_level;
      r_fall  <= r_prev & ~r_level;
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/n64_read_response.sv
// rtl/n64_read_response.sv - receives and decodes the 32-bit controller status response
module n64_read_response
  import n64_pkg::*;
#(
  parameter int P_SAMPLE_AT    = SAMPLE_AT,
  parameter int P_RESP_TIMEOUT = RESP_TIMEOUT,
  parameter int P_BIT_TIMEOUT  = BIT_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_data_in,
  output logic        o_busy,
  output logic [15:0] o_buttons,
  output logic [7:0]  o_joy_x,
  output logic [7:0]  o_joy_y,
  output logic        o_valid,
  output logic        o_err_timeout
);

  localparam int TW = $clog2(max2(P_RESP_TIMEOUT, P_BIT_TIMEOUT)) + 1;
  localparam int CW = $clog2(P_SAMPLE_AT) + 1;
  localparam int BW = $clog2(NUM_BITS) + 1;

  logic w_level;
  logic w_fall;

  n64_sync_edge u_sync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data_in),
    .o_level (w_level),
    .o_fall  (w_fall)
  );

  rx_state_t            r_state;
  logic [TW-1:0]        r_timer;
  logic [CW-1:0]        r_count;
  logic [BW-1:0]        r_bit_idx;
  logic [NUM_BITS-1:0]  r_shift;
  logic                 r_busy;
  logic                 r_valid;
  logic                 r_err;
  logic [15:0]          r_buttons;
  logic [7:0]           r_joy_x;
  logic [7:0]           r_joy_y;

  logic [TW-1:0] w_wait_limit;
  logic [BW-1:0] w_next_idx;

  // The first edge gets the longer controller turnaround allowance.
  assign w_wait_limit = (r_bit_idx == '0) ? TW'(P_RESP_TIMEOUT - 1) : TW'(P_BIT_TIMEOUT - 1);
  assign w_next_idx   = r_bit_idx + BW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_count   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_buttons <= '0;
      r_joy_x   <= '0;
      r_joy_y   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the valid pulse belongs to the finished frame.
          if (i_start && !r_valid) begin
            r_state   <= S_WAIT_EDGE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_WAIT_EDGE: begin
          if (w_fall) begin
            r_state <= S_MEASURE;
            r_count <= '0;
          end else if (r_timer == w_wait_limit) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_MEASURE: begin
          if (r_count == CW'(P_SAMPLE_AT)) begin
            r_shift   <= {r_shift[NUM_BITS-2:0], w_level};
            r_bit_idx <= w_next_idx;
            r_timer   <= '0;
            r_state   <= (w_next_idx == BW'(NUM_BITS)) ? S_STOP : S_WAIT_EDGE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_STOP: begin
          if (w_fall) begin
            r_buttons <= r_shift[BTN_MSB:BTN_LSB];
            r_joy_x   <= r_shift[JX_MSB:JX_LSB];
            r_joy_y   <= r_shift[JY_MSB:JY_LSB];
            r_valid   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_timer == TW'(P_BIT_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_valid       = r_valid;
  assign o_err_timeout = r_err;
  assign o_buttons     = r_buttons;
  assign o_joy_x       = r_joy_x;
  assign o_joy_y       = r_joy_y;

endmodule

// File: tb/tb_n64_read_response.sv
// tb/tb_n64_read_response.sv - self-checking bench for the controller response receiver
module tb_n64_read_response;
  import n64_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        din = 1'b1;
  logic        o_busy, o_valid, o_err_timeout;
  logic [15:0] o_buttons;
  logic [7:0]  o_joy_x, o_joy_y;

  n64_read_response dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_data_in     (din),
    .o_busy        (o_busy),
    .o_buttons     (o_buttons),
    .o_joy_x       (o_joy_x),
    .o_joy_y       (o_joy_y),
    .o_valid       (o_valid),
    .o_err_timeout (o_err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] resp;
    logic [15:0] btn;
    logic [7:0]  jx;
    logic [7:0]  jy;
  } vec_t;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   valid_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  int   busy_drop = 0;
  int   err_cyc = 0;
  logic err_busy = 1'b1;
  logic recv_active = 1'b0;
  vec_t last;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_valid) valid_cnt++;
    if (o_valid && o_err_timeout) both_cnt++;
    if (o_err_timeout) begin
      err_cnt++;
      err_cyc  = cyc;
      err_busy = o_busy;
    end
    if (recv_active && !o_busy) busy_drop++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Line coding as the controller drives it: 1 = low 100 / high 300, 0 = low 300 / high 100.
  task automatic send_bit(input logic b, input logic extra_start);
    int lo;
    lo  = b ? START : DATA;
    din = 1'b0;
    if (extra_start) begin
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(lo - 1);
    end else begin
      tick(lo);
    end
    din = 1'b1;
    tick(CLK_PER_BIT - lo);
  endtask

  function automatic vec_t model(input logic [31:0] r);
    vec_t v;
    v.resp = r;
    v.btn  = 16'(r / 65536);
    v.jx   = 8'((r / 256) % 256);
    v.jy   = 8'(r % 256);
    return v;
  endfunction

  task automatic run_resp(input vec_t v, input int extra_at, input logic start_on_valid, input string tag);
    int   v0;
    int   e0;
    logic seen;
    v0   = valid_cnt;
    e0   = err_cnt;
    seen = 1'b0;
    pulse_start();
    busy_drop   = 0;
    recv_active = 1'b1;
    for (int i = 0; i < NUM_BITS; i++) send_bit(v.resp[31-i], (i == extra_at));
    recv_active = 1'b0;
    din = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    if (seen && start_on_valid) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    tick(START);
    din = 1'b1;
    tick(20);
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_valid_pulses"}, 32'(valid_cnt - v0), 32'd1);
    chk({tag, "_no_err"}, 32'(err_cnt - e0), 32'd0);
    chk({tag, "_busy_held"}, 32'(busy_drop), 32'd0);
    chk({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    chk({tag, "_buttons"}, 32'(o_buttons), 32'(v.btn));
    chk({tag, "_joy_x"}, 32'(o_joy_x), 32'(v.jx));
    chk({tag, "_joy_y"}, 32'(o_joy_y), 32'(v.jy));
    last = v;
  endtask

  vec_t table_v[3];

  initial begin
    int s;
    int c;
    int v0;
    int e0;
    int d;

    table_v[0] = '{32'h0000_0000, 16'h0000, 8'h00, 8'h00};
    table_v[1] = '{32'h8000_7F81, 16'h8000, 8'h7F, 8'h81};
    table_v[2] = model($urandom);

    tick(5);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_err", 32'(o_err_timeout), 32'd0);
    chk("reset_buttons", 32'(o_buttons), 32'd0);
    chk("reset_joy", {16'd0, o_joy_x, o_joy_y}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // The middle entry also checks that a start during the valid pulse is dropped.
    for (int i = 0; i < 3; i++)
      run_resp(table_v[i], -1, (i == 1), $sformatf("table%0d", i));

    // Line held high after arming: response timeout.
    v0 = valid_cnt;
    e0 = err_cnt;
    pulse_start();
    s = cyc;
    tick(RESP_TIMEOUT + 10);
    chk("resp_to_pulses", 32'(err_cnt - e0), 32'd1);
    chk("resp_to_cycle", 32'(err_cyc - s), 32'(RESP_TIMEOUT));
    chk("resp_to_busy", 32'(err_busy), 32'd0);
    chk("resp_to_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("resp_to_outputs", {o_buttons, o_joy_x, o_joy_y}, {last.btn, last.jx, last.jy});

    // Line stuck high after bit 20: inter-bit timeout measured from that bit's fall.
    v0 = valid_cnt;
    e0 = err_cnt;
    pulse_start();
    for (int i = 0; i < 20; i++) send_bit(1'($urandom), 1'b0);
    din = 1'b0;
    c = cyc;
    tick(START);
    din = 1'b1;
    tick(SAMPLE_AT + BIT_TIMEOUT + 100);
    d = err_cyc - c;
    chk("bit_to_pulses", 32'(err_cnt - e0), 32'd1);
    chk("bit_to_window", 32'((d >= SAMPLE_AT + BIT_TIMEOUT) && (d <= SAMPLE_AT + BIT_TIMEOUT + 8)), 32'd1);
    chk("bit_to_busy", 32'(err_busy), 32'd0);
    chk("bit_to_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("bit_to_outputs", {o_buttons, o_joy_x, o_joy_y}, {last.btn, last.jx, last.jy});

    // Reset in the middle of bit 10.
    v0 = valid_cnt;
    pulse_start();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0);
    din = 1'b0;
    tick(50);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_outputs", {o_buttons, o_joy_x, o_joy_y}, 32'd0);
    tick(5);
    din = 1'b1;
    rst_n = 1'b1;
    tick(5);
    chk("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
    run_resp(model(32'hFFFF_FFFF), -1, 1'b0, "after_rst");

    // Random response with a second start pulse at bit 5.
    run_resp(model($urandom), 5, 1'b0, "extra_start");

    chk("never_valid_and_err", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
